// File: rtl/mfp_ahb_input_reader_if.sv
// AHB-Lite slave-side bus bundle for the MFP input reader.
interface mfp_ahb_input_reader_if;
    logic [7:0]  HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;

    modport master (output HADDR, HWDATA, HWRITE, HSEL, input HRDATA);
    modport slave  (input HADDR, HWDATA, HWRITE, HSEL, output HRDATA);
endinterface

// File: rtl/mfp_ahb_input_reader.sv
// MFP AHB-Lite input reader: debounced switches/buttons and a sticky button-press latch.
// Defining MFP_INPUT_READER_IRQ_EN adds the IRQ output and the 0x10 IRQ_MASK register.
module mfp_ahb_input_reader #(
    parameter int TICK_CYCLES    = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter int N_SW           = 16,
    parameter int N_PB           = 5
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    mfp_ahb_input_reader_if.slave bus,
    input  logic [N_SW-1:0]       IO_SW,
    input  logic [N_PB-1:0]       IO_PB
`ifdef MFP_INPUT_READER_IRQ_EN
    ,
    output logic                  IRQ
`endif
);
    localparam int              TW        = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [7:0]      OFF_SW    = 8'h00;
    localparam logic [7:0]      OFF_PB    = 8'h04;
    localparam logic [7:0]      OFF_EDGE  = 8'h08;
    localparam logic [7:0]      OFF_W1C   = 8'h0C;
`ifdef MFP_INPUT_READER_IRQ_EN
    localparam logic [7:0]      OFF_MASK  = 8'h10;
`endif

    logic [N_SW-1:0] sw_meta, sw_sync, sw_deb, sw_deb_next, sw_all1, sw_all0;
    logic [N_PB-1:0] pb_meta, pb_sync, pb_deb, pb_deb_next, pb_all1, pb_all0;
    logic [STABLE_SAMPLES-1:0][N_SW-1:0] sw_hist, sw_hist_next;
    logic [STABLE_SAMPLES-1:0][N_PB-1:0] pb_hist, pb_hist_next;
    logic [TW-1:0]   tick_cnt;
    logic            strobe;
    logic [N_PB-1:0] pb_edge, pb_edge_next, pb_rise, clr_mask;
    logic [7:0]      d_addr;
    logic            d_write, d_sel;
    logic            rd_req, rd_clr, wr_act, w1c;
    logic [31:0]     rd_data, hrdata;
    logic            unused_hwdata;
`ifdef MFP_INPUT_READER_IRQ_EN
    logic [N_PB-1:0] irq_mask;
`endif

    assign strobe = (tick_cnt == TICK_LAST);

    // A debounced bit follows its history only once every sample in it agrees.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        sw_hist_next = sw_hist;
        pb_hist_next = pb_hist;
        sw_deb_next  = sw_deb;
        pb_deb_next  = pb_deb;
        if (strobe) begin
            sw_hist_next = {sw_hist[STABLE_SAMPLES-2:0], sw_sync};
            pb_hist_next = {pb_hist[STABLE_SAMPLES-2:0], pb_sync};
        end
        sw_all1 = '1;
        sw_all0 = '1;
        pb_all1 = '1;
        pb_all0 = '1;
        for (int k = 0; k < STABLE_SAMPLES; k++) begin
            sw_all1 &= sw_hist_next[k];
            sw_all0 &= ~sw_hist_next[k];
            pb_all1 &= pb_hist_next[k];
            pb_all0 &= ~pb_hist_next[k];
        end
        if (strobe) begin
            sw_deb_next = (sw_deb & ~sw_all0) | sw_all1;
            pb_deb_next = (pb_deb & ~pb_all0) | pb_all1;
        end
    end

    assign rd_req = bus.HSEL & ~bus.HWRITE;
    assign rd_clr = rd_req & (bus.HADDR == OFF_EDGE);
    assign wr_act = d_sel & d_write;
    assign w1c    = wr_act & (d_addr == OFF_W1C);

    always_comb begin
        rd_data = '0;
        case (bus.HADDR)
            OFF_SW:            rd_data = 32'(sw_deb);
            OFF_PB:            rd_data = 32'(pb_deb);
            OFF_EDGE, OFF_W1C: rd_data = 32'(pb_edge);
`ifdef MFP_INPUT_READER_IRQ_EN
            OFF_MASK:          rd_data = 32'(irq_mask);
`endif
            default:           rd_data = '0;
        endcase
    end

    // A fresh press always survives a clear landing on the same edge.
    assign pb_rise      = pb_deb_next & ~pb_deb;
    assign clr_mask     = (rd_clr ? pb_edge : '0) | (w1c ? bus.HWDATA[N_PB-1:0] : '0);
    assign pb_edge_next = (pb_edge & ~clr_mask) | pb_rise;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            pb_meta  <= '0;
            pb_sync  <= '0;
            tick_cnt <= '0;
            // NOTE: the sample history is reset too; stale history could pass the all-equal test.
            sw_hist  <= '0;
            pb_hist  <= '0;
            sw_deb   <= '0;
            pb_deb   <= '0;
            pb_edge  <= '0;
            d_addr   <= '0;
            d_write  <= 1'b0;
            d_sel    <= 1'b0;
            hrdata   <= '0;
        end else begin
            sw_meta  <= IO_SW;
            sw_sync  <= sw_meta;
            pb_meta  <= IO_PB;
            pb_sync  <= pb_meta;
            tick_cnt <= strobe ? '0 : tick_cnt + 1'b1;
            sw_hist  <= sw_hist_next;
            pb_hist  <= pb_hist_next;
            sw_deb   <= sw_deb_next;
            pb_deb   <= pb_deb_next;
            pb_edge  <= pb_edge_next;
            d_addr   <= bus.HADDR;
            d_write  <= bus.HWRITE;
            d_sel    <= bus.HSEL;
            if (rd_req) hrdata <= rd_data;
        end
    end

`ifdef MFP_INPUT_READER_IRQ_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_mask <= '0;
            IRQ      <= 1'b0;
        end else begin
            if (wr_act && d_addr == OFF_MASK) irq_mask <= bus.HWDATA[N_PB-1:0];
            IRQ <= |(pb_edge & irq_mask);
        end
    end
`endif

    assign bus.HRDATA   = hrdata;
    assign unused_hwdata = ^bus.HWDATA[31:N_PB];
endmodule

// File: tb/tb_mfp_ahb_input_reader.sv
// Randomised scoreboard bench for mfp_ahb_input_reader against a settled-pin register model.
module tb_mfp_ahb_input_reader;
    localparam int TICK = 4;
    localparam int SAMP = 4;
    localparam int N_SW = 16;
    localparam int N_PB = 5;
    localparam int SETTLE = 2 + SAMP * TICK;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } exp_t;

    logic            HCLK = 1'b0;
    logic            HRESETn = 1'b0;
    logic [N_SW-1:0] IO_SW = '0;
    logic [N_PB-1:0] IO_PB = '0;
`ifdef MFP_INPUT_READER_IRQ_EN
    logic            IRQ;
`endif

    mfp_ahb_input_reader_if bus ();

    mfp_ahb_input_reader #(
        .TICK_CYCLES(TICK), .STABLE_SAMPLES(SAMP), .N_SW(N_SW), .N_PB(N_PB)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bus),
        .IO_SW(IO_SW),
        .IO_PB(IO_PB)
`ifdef MFP_INPUT_READER_IRQ_EN
        , .IRQ(IRQ)
`endif
    );

    always #5 HCLK = ~HCLK;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   rd_phase = 1'b0;
    exp_t sb[$];

    logic [N_SW-1:0] m_sw   = '0;
    logic [N_PB-1:0] m_pb   = '0;
    logic [N_PB-1:0] m_edge = '0;
    logic [N_PB-1:0] m_mask = '0;
    bit              pend_wr = 1'b0;
    logic [7:0]      pend_a  = '0;
    logic [31:0]     pend_d  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a read seen at a rising edge is checked mid-way through its data phase.
    always @(posedge HCLK) begin
        if (HRESETn) cyc = cyc + 1;
        rd_phase = HRESETn && bus.HSEL && !bus.HWRITE;
    end

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            rd_phase = 1'b0;
        end else if (rd_phase) begin
            rd_phase = 1'b0;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_read: got %h expected no read", bus.HRDATA);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("rd@%02h", e.a), bus.HRDATA, e.d);
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:        return 32'(m_sw);
            8'h04:        return 32'(m_pb);
            8'h08, 8'h0C: return 32'(m_edge);
`ifdef MFP_INPUT_READER_IRQ_EN
            8'h10:        return 32'(m_mask);
`endif
            default:      return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d);
        if (a == 8'h0C) m_edge = m_edge & ~d[N_PB-1:0];
`ifdef MFP_INPUT_READER_IRQ_EN
        if (a == 8'h10) m_mask = d[N_PB-1:0];
`endif
    endfunction

    // Drives one address phase (plus the previous write's data) and advances one cycle.
    task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d);
        exp_t e;
        bus.HSEL   = 1'b1;
        bus.HWRITE = wr;
        bus.HADDR  = a;
        bus.HWDATA = pend_wr ? pend_d : $urandom();
        e.a = a;
        e.d = model_read(a);
        if (!wr) sb.push_back(e);
        if (pend_wr) model_write(pend_a, pend_d);
        if (!wr && a == 8'h08) m_edge = m_edge & ~e.d[N_PB-1:0];
        pend_wr = wr;
        pend_a  = a;
        pend_d  = d;
        @(negedge HCLK);
    endtask

    task automatic idle();
        bus.HSEL   = 1'b0;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 8'($urandom());
        bus.HWDATA = pend_wr ? pend_d : $urandom();
        if (pend_wr) model_write(pend_a, pend_d);
        pend_wr = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic apply_pins(input logic [N_SW-1:0] sw, input logic [N_PB-1:0] pb);
        IO_SW = sw;
        IO_PB = pb;
        repeat (SETTLE) idle();
        m_edge = m_edge | (pb & ~m_pb);
        m_sw   = sw;
        m_pb   = pb;
    endtask

    task automatic do_reset();
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        bus.HSEL = 1'b0;
        bus.HWRITE = 1'b0;
        @(negedge HCLK);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        cyc = 0;
        m_sw = '0; m_pb = '0; m_edge = '0; m_mask = '0;
        pend_wr = 1'b0;
        sb.delete();
        @(negedge HCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] offs [7];
        int e_edge, first_s, d_edge, k;

        bus.HSEL = 1'b0; bus.HWRITE = 1'b0; bus.HADDR = '0; bus.HWDATA = '0;
        do_reset();
        issue(0, 8'h00, 0); issue(0, 8'h04, 0); issue(0, 8'h08, 0); idle();

        // Switch debounce at worst-case latency, then a short glitch that must be ignored.
        apply_pins(16'hA5A5, '0);
        issue(0, 8'h00, 0); idle();
        IO_SW = '0;
        repeat (3) idle();
        IO_SW = 16'hA5A5;
        repeat (SETTLE) idle();
        issue(0, 8'h00, 0); idle();

        // Press/release PB0; clear-on-read.
        apply_pins(16'hA5A5, 5'h01);
        apply_pins(16'hA5A5, 5'h00);
        issue(0, 8'h08, 0); issue(0, 8'h08, 0); issue(0, 8'h04, 0); idle();

        // W1C leaves bit 4, then a PB0 edge collides with a 0x08 read.
        apply_pins(16'hA5A5, 5'h11);
        apply_pins(16'hA5A5, 5'h00);
        issue(1, 8'h0C, 32'h1); idle();
        issue(0, 8'h0C, 0); idle();
        IO_PB = 5'h01;
        e_edge  = cyc + 1;
        first_s = ((e_edge + 2 + TICK - 1) / TICK) * TICK;
        d_edge  = first_s + (SAMP - 1) * TICK;
        while (cyc < d_edge - 1) idle();
        issue(0, 8'h08, 0);
        m_edge = m_edge | 5'h01;
        m_pb   = 5'h01;
        issue(0, 8'h08, 0); idle();
        apply_pins(16'hA5A5, 5'h00);

        // Back-to-back reads, unmapped offset, write-then-read without a bubble.
        issue(0, 8'h00, 0); issue(0, 8'h04, 0); issue(0, 8'h20, 0); idle();
        apply_pins(16'h1234, 5'h06);
        issue(1, 8'h0C, 32'h2); issue(0, 8'h08, 0); issue(0, 8'h08, 0); idle();

`ifdef MFP_INPUT_READER_IRQ_EN
        issue(1, 8'h10, 32'h4); idle();
        issue(0, 8'h10, 0); issue(0, 8'h08, 0); idle();
        apply_pins(16'h1234, 5'h01);
        apply_pins(16'h1234, 5'h00);
        check("irq_pb0_masked", 32'(IRQ), 32'h0);
        apply_pins(16'h1234, 5'h04);
        check("irq_pb2", 32'(IRQ), 32'h1);
        apply_pins(16'h1234, 5'h00);
        issue(0, 8'h08, 0); idle();
        check("irq_cleared", 32'(IRQ), 32'h0);
`endif

        // Randomised pins and bus traffic.
        for (int it = 0; it < 30; it++) begin
            apply_pins(N_SW'($urandom()), N_PB'($urandom()));
`ifdef MFP_INPUT_READER_IRQ_EN
            check("irq_rand", 32'(IRQ), 32'(|(m_edge & m_mask)));
`endif
            for (int j = 0; j < 6; j++) begin
                offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
                offs[4] = 8'h10; offs[5] = 8'h20; offs[6] = 8'($urandom());
                k = $urandom_range(0, 9);
                case (k)
                    6:       issue(1, 8'h0C, $urandom());
                    7:       issue(1, 8'h10, $urandom());
                    8:       issue(1, 8'h00, $urandom());
                    9:       issue(1, 8'h04, $urandom());
                    default: issue(0, offs[$urandom_range(0, 6)], 0);
                endcase
            end
            idle();
        end

        // Reset in the middle of a read's data phase drops it.
        apply_pins(16'hBEEF, 5'h00);
        bus.HSEL = 1'b1; bus.HWRITE = 1'b0; bus.HADDR = 8'h00;
        do_reset();
        issue(0, 8'h00, 0); idle();
        apply_pins(16'hBEEF, 5'h00);
        issue(0, 8'h00, 0); idle();

        idle(); idle();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mfp_ahb_input_reader.md
Name: mfp_ahb_input_reader

Overview:
- AHB-Lite read-side slave on the MFP peripheral bus. It supplies HRDATA for the board's slide switches and pushbuttons.
- It synchronises and debounces the raw pins and latches pushbutton press edges until software collects them.
- It is the read-path counterpart of the bus's write-only display peripherals. It sits beside them on the same HSEL decode.

Parameters:
- TICK_CYCLES, 50000: HCLK cycles between debounce samples (1 ms at 50 MHz); legal range ≥2.
- STABLE_SAMPLES, 4: number of consecutive equal samples required before a debounced bit changes; range 2..8.
- N_SW, 16: number of slide switch inputs.
- N_PB, 5: number of pushbutton inputs.

Ports:
- HCLK  in  1  bus clock; the only clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  8  byte address, low 8 bits; sampled in the address phase.
- HWDATA  in  32  write data, valid in the data phase.
- HWRITE  in  1  1 = write, 0 = read; sampled in the address phase.
- HSEL  in  1  slave select; sampled in the address phase.
- HRDATA  out  32  read data, valid in the data phase.
- IO_SW  in  N_SW  raw switch pins; asynchronous.
- IO_PB  in  N_PB  raw pushbutton pins; asynchronous; active-high.

Behaviour:
- Reset (HRESETn low, asynchronous): HRDATA=0, all synchronisers=0, sample history=0, debounced SW/PB=0, edge latch=0, tick counter=0, delayed address/write/select=0.
- Synchronisers: a 2-flop synchroniser on every IO_SW/IO_PB bit.
- Tick counter: counts 0..TICK_CYCLES-1 and then wraps. A sample strobe asserts for one cycle at the wrap.
- Sample history: on each strobe, every bit shifts its synchronised value into a STABLE_SAMPLES-deep history.
- Debounce update: a debounced bit takes the new value only when the entire history is all-1 or all-0. Otherwise it holds.
- Worst-case pin-to-debounced latency: 2 + STABLE_SAMPLES*TICK_CYCLES cycles.
- Edge latch: PB_EDGE[i] sets when debounced PB[i] goes 0->1. It is sticky and cleared only by software. A 1->0 transition does not set it.
- Register map (byte offsets, 32-bit, unused bits read 0):
  - 0x00 SW: debounced switches; read-only.
  - 0x04 PB: debounced buttons; read-only.
  - 0x08 PB_EDGE: edge latch; clear-on-read.
  - 0x0C PB_EDGE_W1C: write-1-to-clear the edge latch; reads return PB_EDGE without clearing.
  - Any other offset: reads 0, writes ignored.
- Read timing:
  - Address phase at edge N with HSEL=1 and HWRITE=0: HRDATA is registered from the offset decode at edge N. It is valid for the whole data phase up to edge N+1.
  - HRDATA holds its last value when no read is in progress.
  - Zero wait states; no HREADYOUT is generated.
- Write timing:
  - HADDR, HWRITE and HSEL are delayed one cycle.
  - A write acts at the data-phase edge using HWDATA and the delayed address.
- Clear-on-read (0x08): the bits returned in HRDATA clear at the same edge that registers HRDATA.
- Simultaneous events on the edge latch:
  - A new edge arriving on the same cycle as a clear-on-read or W1C clear wins: the bit stays 1.
  - W1C clears only the bits written as 1.
- Back-to-back accesses:
  - A read following a write is supported with no bubble.
  - When a W1C write's data-phase edge coincides with a 0x08 read's address edge, the read returns the pre-clear value. The bit clears if either the W1C or the read clears it.
- Reset mid-transfer: everything returns to reset values immediately. The transfer in flight is dropped, and HRDATA reads 0.

Optional Feature:
- Macro: MFP_INPUT_READER_IRQ_EN.
- When defined:
  - Adds the output port IRQ (out, 1), registered: IRQ = |(PB_EDGE & IRQ_MASK).
  - Adds the register 0x10 IRQ_MASK: N_PB bits, read/write, reset 0.
  - IRQ deasserts on the cycle after the last enabled edge bit clears.
- When undefined:
  - No IRQ port.
  - 0x10 reads 0 and writes are ignored.

Test Plan:
- Reset and idle: release reset with TICK_CYCLES=4, STABLE_SAMPLES=4 -> reads at 0x00, 0x04 and 0x08 all return 0x00000000.
- Switch debounce: set IO_SW=0xA5A5 and hold -> 0x00 reads 0xA5A5 within 18 cycles. A 3-cycle glitch to 0x0000 -> 0x00 still reads 0xA5A5.
- Button edge, clear-on-read:
  - Press IO_PB=0x01 and hold, then release.
  - First 0x08 read returns 0x01; second read returns 0x00.
  - 0x04 reads 0x00 after the release.
- W1C and collision:
  - Latch PB_EDGE=0x11, write 0x01 to 0x0C -> 0x0C then reads 0x10.
  - Force a new PB[0] edge on the same cycle as a 0x08 read -> that read returns 0x10, and the next 0x08 read returns 0x01.
- Bus timing:
  - Issue back-to-back reads of 0x00 then 0x04 -> each HRDATA is valid exactly one cycle after its address phase.
  - A read of offset 0x20 returns 0.
- IRQ (MFP_INPUT_READER_IRQ_EN):
  - Write 0x04 to 0x10, then press PB[2] -> IRQ=1.
  - Press PB[0] alone -> IRQ stays 0.
  - Read 0x08 -> IRQ returns to 0 on the following cycle.
